// File: rtl/rob_alloc_if.sv
// Allocation handshake, credit and drain signals shared between the ROB
// allocation arbiter and its issue requesters.
interface rob_alloc_if #(
    parameter int NUM_REQ  = 4,
    parameter int ROB_ID_W = 4,
    parameter int SRC_W    = 2
) ();
    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ-1:0]  req_ready;
    logic                alloc_valid;
    logic [ROB_ID_W-1:0] alloc_rob_id;
    logic [SRC_W-1:0]    alloc_src;
    logic                crdt_rtn;
    logic [ROB_ID_W:0]   crdt_avail;
    logic                drain_req;
    logic                drain_done;
    logic                crdt_err;

    modport master (
        output req_valid, crdt_rtn, drain_req,
        input  req_ready, alloc_valid, alloc_rob_id, alloc_src,
               crdt_avail, drain_done, crdt_err
    );

    modport slave (
        input  req_valid, crdt_rtn, drain_req,
        output req_ready, alloc_valid, alloc_rob_id, alloc_src,
               crdt_avail, drain_done, crdt_err
    );
endinterface

// File: rtl/rob_alloc_arb.sv
// Round-robin ROB entry allocator: zero-latency grant, credit tracking of free
// entries, and a drain mode that halts allocation until the ROB is empty.
module rob_alloc_arb #(
    parameter int NUM_REQ  = 4,
    parameter int ROB_SIZE = 16,
    parameter int ROB_ID_W = 4,
    parameter int SRC_W    = 2
) (
    input  logic         clk,
    input  logic         rst,
    rob_alloc_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [ROB_ID_W:0] CRDT_FULL = (ROB_ID_W+1)'(ROB_SIZE);
    localparam logic [ROB_ID_W:0] CRDT_ONE  = (ROB_ID_W+1)'(1);

    state_t              state_q, state_d;
    logic [ROB_ID_W:0]   crdt_q, crdt_d;
    logic [ROB_ID_W-1:0] ptr_q, ptr_d;
    logic [SRC_W-1:0]    prio_q, prio_d;
    logic                err_q, err_d;

    logic                gnt;
    logic [SRC_W-1:0]    gnt_idx;

    // Requester index at distance off from base, wrapping at NUM_REQ.
    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return SRC_W'(s);
    endfunction

    // Scan from the lowest priority up so the last hit is the highest-priority requester.
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        if (!rst && state_q == ST_RUN && !bus.drain_req && crdt_q != '0) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[rr_idx(prio_q, k)]) begin
                    gnt     = 1'b1;
                    gnt_idx = rr_idx(prio_q, k);
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt) bus.req_ready[gnt_idx] = 1'b1;
    end

    assign bus.alloc_valid  = gnt;
    assign bus.alloc_rob_id = ptr_q;
    assign bus.alloc_src    = gnt_idx;
    assign bus.crdt_avail   = crdt_q;
    assign bus.drain_done   = (state_q == ST_DONE);
    assign bus.crdt_err     = err_q;

    always_comb begin
        ptr_d   = ptr_q;
        prio_d  = prio_q;
        crdt_d  = crdt_q;
        err_d   = err_q;
        state_d = state_q;

        if (gnt) begin
            ptr_d  = ptr_q + ROB_ID_W'(1);
            prio_d = rr_idx(gnt_idx, 1);
        end

        // A return racing a grant cancels out; a return into a full pool is a protocol error.
        case ({gnt, bus.crdt_rtn})
            2'b10:   crdt_d = crdt_q - CRDT_ONE;
            2'b01: begin
                if (crdt_q == CRDT_FULL) err_d  = 1'b1;
                else                     crdt_d = crdt_q + CRDT_ONE;
            end
            default: ;
        endcase

        case (state_q)
            ST_RUN:   if (bus.drain_req)        state_d = ST_DRAIN;
            ST_DRAIN: if (crdt_q == CRDT_FULL)  state_d = ST_DONE;
            ST_DONE:  if (!bus.drain_req)       state_d = ST_RUN;
            default:                            state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            crdt_q  <= CRDT_FULL;
            ptr_q   <= '0;
            prio_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crdt_q  <= crdt_d;
            ptr_q   <= ptr_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rob_alloc_arb.sv
// Bench for rob_alloc_arb: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based model of the ROB.
module tb_rob_alloc_arb;
    localparam int NR = 4;
    localparam int RS = 16;
    localparam int IW = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_alloc_if #(.NUM_REQ(NR), .ROB_ID_W(IW), .SRC_W(SW)) bus ();

    rob_alloc_arb #(.NUM_REQ(NR), .ROB_SIZE(RS), .ROB_ID_W(IW), .SRC_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: outstanding ROB ids in allocation order; free count is what is left.
    int q_ids[$];
    int m_next = 0;
    int m_prio = 0;
    int m_mode = 0;   // 0 allocating, 1 draining, 2 drained
    bit m_err  = 1'b0;
    bit m_init = 1'b0;

    always @(negedge clk) begin : cmp
        int free, e_idx, c;
        bit e_gnt;
        logic [NR-1:0] e_rdy;
        free  = RS - q_ids.size();
        e_gnt = 1'b0;
        e_idx = 0;
        if (!rst && m_init && m_mode == 0 && !bus.drain_req && free > 0) begin
            for (int k = 0; k < NR; k++) begin
                c = (m_prio + k) % NR;
                if (!e_gnt && bus.req_valid[c]) begin
                    e_gnt = 1'b1;
                    e_idx = c;
                end
            end
        end
        e_rdy = e_gnt ? NR'(1 << e_idx) : '0;

        chk("m_ready", int'(bus.req_ready), int'(e_rdy));
        chk("m_valid", int'(bus.alloc_valid), int'(e_gnt));
        chk("m_src", int'(bus.alloc_src), e_idx);
        if (m_init) begin
            chk("m_id", int'(bus.alloc_rob_id), m_next);
            chk("m_avail", int'(bus.crdt_avail), free);
            chk("m_done", int'(bus.drain_done), int'(m_mode == 2));
            chk("m_err", int'(bus.crdt_err), int'(m_err));
        end

        if (rst) begin
            q_ids.delete();
            m_next = 0;
            m_prio = 0;
            m_err  = 1'b0;
            m_mode = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            if (e_gnt) begin
                q_ids.push_back(m_next);
                m_next = (m_next + 1) % RS;
                m_prio = (e_idx + 1) % NR;
            end
            if (bus.crdt_rtn) begin
                if (q_ids.size() > 0) void'(q_ids.pop_front());
                else m_err = 1'b1;
            end
            case (m_mode)
                0: if (bus.drain_req) m_mode = 1;
                1: if (free == RS) m_mode = 2;
                default: if (!bus.drain_req) m_mode = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.crdt_rtn  = 1'b0;
        bus.drain_req = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int pct;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.crdt_rtn  = 1'b0;
        bus.drain_req = 1'b0;
        cyc();
        cyc();

        // Reset values, and no grant while reset is held.
        bus.req_valid = 4'hF;
        #1;
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_avail", int'(bus.crdt_avail), 16);
        chk("rst_err", int'(bus.crdt_err), 0);
        chk("rst_done", int'(bus.drain_done), 0);
        cyc();
        rst = 1'b0;

        // All four requesting: strict rotation, ids 0..7.
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("a_src", int'(bus.alloc_src), i % 4);
            chk("a_id", int'(bus.alloc_rob_id), i);
            cyc();
        end
        bus.req_valid = '0;
        #1;
        chk("a_avail", int'(bus.crdt_avail), 8);

        // Single requester exhausts all 16 credits.
        do_reset();
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("b_ready", int'(bus.req_ready), 4);
            chk("b_id", int'(bus.alloc_rob_id), i);
            cyc();
        end
        #1;
        chk("b_empty_ready", int'(bus.req_ready), 0);
        chk("b_empty_avail", int'(bus.crdt_avail), 0);
        bus.crdt_rtn = 1'b1;
        #1;
        chk("b_rtn_no_gnt", int'(bus.req_ready), 0);
        cyc();
        bus.crdt_rtn = 1'b0;
        #1;
        chk("b_avail1", int'(bus.crdt_avail), 1);
        chk("b_regrant", int'(bus.req_ready), 4);
        chk("b_wrap_id", int'(bus.alloc_rob_id), 0);
        cyc();
        bus.req_valid = '0;

        // Grant and return together leave the count unchanged.
        do_reset();
        bus.req_valid = 4'b0001;
        repeat (11) cyc();
        #1;
        chk("c_avail5", int'(bus.crdt_avail), 5);
        bus.crdt_rtn = 1'b1;
        #1;
        chk("c_gnt", int'(bus.req_ready), 1);
        cyc();
        bus.crdt_rtn  = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("c_still5", int'(bus.crdt_avail), 5);

        // Drain with 6 outstanding entries.
        do_reset();
        bus.req_valid = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("d_src", int'(bus.alloc_src), i % 2);
            cyc();
        end
        bus.req_valid = 4'hF;
        bus.drain_req = 1'b1;
        #1;
        chk("d_block", int'(bus.req_ready), 0);
        chk("d_avail10", int'(bus.crdt_avail), 10);
        cyc();
        for (int i = 0; i < 6; i++) begin
            bus.crdt_rtn = 1'b1;
            #1;
            chk("d_drain_ready", int'(bus.req_ready), 0);
            chk("d_drain_done0", int'(bus.drain_done), 0);
            cyc();
        end
        bus.crdt_rtn = 1'b0;
        #1;
        chk("d_full", int'(bus.crdt_avail), 16);
        chk("d_not_yet", int'(bus.drain_done), 0);
        cyc();
        #1;
        chk("d_done", int'(bus.drain_done), 1);
        chk("d_done_ready", int'(bus.req_ready), 0);
        bus.drain_req = 1'b0;
        #1;
        chk("d_done_nogrant", int'(bus.req_ready), 0);
        cyc();
        #1;
        chk("d_run", int'(bus.drain_done), 0);
        chk("d_prio_kept", int'(bus.req_ready), 4);
        chk("d_ptr_kept", int'(bus.alloc_rob_id), 6);
        cyc();
        bus.req_valid = '0;

        // Spurious return sets the sticky error; reset clears everything.
        do_reset();
        bus.crdt_rtn = 1'b1;
        cyc();
        bus.crdt_rtn = 1'b0;
        #1;
        chk("e_err", int'(bus.crdt_err), 1);
        chk("e_avail", int'(bus.crdt_avail), 16);
        bus.req_valid = 4'b1000;
        repeat (3) cyc();
        bus.req_valid = '0;
        #1;
        chk("e_avail13", int'(bus.crdt_avail), 13);
        rst = 1'b1;
        bus.crdt_rtn = 1'b1;
        cyc();
        rst = 1'b0;
        bus.crdt_rtn = 1'b0;
        #1;
        chk("e_rst_avail", int'(bus.crdt_avail), 16);
        chk("e_rst_err", int'(bus.crdt_err), 0);
        bus.req_valid = 4'b1000;
        #1;
        chk("e_rst_id", int'(bus.alloc_rob_id), 0);
        chk("e_rst_ready", int'(bus.req_ready), 8);
        cyc();
        bus.req_valid = '0;

        // Randomized traffic; return rate varies per epoch to hit both empty and full.
        pct = 40;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) pct = int'($urandom_range(15, 75));
            rst           = ($urandom_range(0, 299) == 0);
            bus.req_valid = NR'($urandom);
            bus.crdt_rtn  = ($urandom_range(0, 99) < pct);
            if ($urandom_range(0, 59) == 0) bus.drain_req = ~bus.drain_req;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
